ram_sp_arbiter: RTL and testbench

Two-port round-robin arbiter that shares one single-port RAM (`ram_sp`, one-cycle registered read, read-first on write) between two requesters, A and B. Each requester has a valid/ready request channel and a registered read-response strobe. An optional lock gives one requester back-to-back ownership for atomic bursts, bounded by a lock-length limit. It sits between two datapath clients (e.g. a DMA and a CPU-side register path) and the RAM instance.

---
 rtl/ram_sp_arbiter.sv | 115 +++++++++++
 tb/tb_ram_sp_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_sp_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between requesters A and B,
// with an optional bounded lock that keeps ownership across an atomic burst.
module ram_sp_arbiter #(
  parameter int DATA_WIDTH_P = -1,
  parameter int ADDR_WIDTH_P = -1,
  parameter int MAX_LOCK_P   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    a_req_valid,
  output logic                    a_req_ready,
  input  logic                    a_req_write,
  input  logic                    a_req_lock,
  input  logic [ADDR_WIDTH_P-1:0] a_req_addr,
  input  logic [DATA_WIDTH_P-1:0] a_req_data,
  input  logic                    b_req_valid,
  output logic                    b_req_ready,
  input  logic                    b_req_write,
  input  logic                    b_req_lock,
  input  logic [ADDR_WIDTH_P-1:0] b_req_addr,
  input  logic [DATA_WIDTH_P-1:0] b_req_data,
  output logic                    a_rsp_valid,
  output logic                    b_rsp_valid,
  output logic [DATA_WIDTH_P-1:0] rsp_data,
  output logic                    ram_enable,
  output logic                    ram_write_enable,
  output logic [ADDR_WIDTH_P-1:0] ram_address,
  output logic [DATA_WIDTH_P-1:0] ram_data_ingress,
  input  logic [DATA_WIDTH_P-1:0] ram_data_egress
);

  typedef enum logic [1:0] {IDLE, LOCK_A, LOCK_B} state_t;

  localparam logic [15:0] MaxLock = 16'(MAX_LOCK_P);

  state_t      r_state;
  logic [15:0] r_lock_cnt;
  logic        r_last_b;
  logic        r_a_rsp;
  logic        r_b_rsp;

  logic        w_a_gnt;
  logic        w_b_gnt;
  logic        w_acc;
  logic        w_lock;
  logic [15:0] w_next_cnt;

  // Grants are gated by reset so nothing is accepted while rst is high.
  always_comb begin
    w_a_gnt = 1'b0;
    w_b_gnt = 1'b0;
    if (!rst) begin
      case (r_state)
        IDLE: begin
          w_a_gnt = a_req_valid && (!b_req_valid || r_last_b);
          w_b_gnt = b_req_valid && (!a_req_valid || !r_last_b);
        end
        LOCK_A:  w_a_gnt = a_req_valid;
        LOCK_B:  w_b_gnt = b_req_valid;
        default: ;
      endcase
    end
  end

  assign w_acc      = w_a_gnt || w_b_gnt;
  assign w_lock     = w_a_gnt ? a_req_lock : b_req_lock;
  // Count of locked grants including this one; reaching the limit releases.
  assign w_next_cnt = (r_state == IDLE) ? 16'd1 : r_lock_cnt + 16'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_lock_cnt <= '0;
      r_last_b   <= 1'b1;
      r_a_rsp    <= 1'b0;
      r_b_rsp    <= 1'b0;
    end else begin
      r_a_rsp <= w_a_gnt && !a_req_write;
      r_b_rsp <= w_b_gnt && !b_req_write;
      if (w_acc) begin
        r_last_b <= w_b_gnt;
        if (w_lock && (w_next_cnt < MaxLock)) begin
          r_state    <= w_a_gnt ? LOCK_A : LOCK_B;
          r_lock_cnt <= w_next_cnt;
        end else begin
          r_state    <= IDLE;
          r_lock_cnt <= '0;
        end
      end
    end
  end

  always_comb begin
    ram_write_enable = 1'b0;
    ram_address      = '0;
    ram_data_ingress = '0;
    if (w_a_gnt) begin
      ram_write_enable = a_req_write;
      ram_address      = a_req_addr;
      ram_data_ingress = a_req_data;
    end else if (w_b_gnt) begin
      ram_write_enable = b_req_write;
      ram_address      = b_req_addr;
      ram_data_ingress = b_req_data;
    end
  end

  assign ram_enable  = w_acc;
  assign a_req_ready = w_a_gnt;
  assign b_req_ready = w_b_gnt;
  assign a_rsp_valid = r_a_rsp;
  assign b_rsp_valid = r_b_rsp;
  assign rsp_data    = ram_data_egress;

endmodule

// File: tb/tb_ram_sp_arbiter.sv
// Directed bench for ram_sp_arbiter: a read-first RAM model behind the main
// instance, plus a MAX_LOCK_P=3 instance sharing the inputs for lock timeout.
module tb_ram_sp_arbiter;
  localparam int DW = 8;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          a_v, a_w, a_l, b_v, b_w, b_l;
  logic [AW-1:0] a_ad, b_ad;
  logic [DW-1:0] a_d, b_d;
  logic          a_rdy, b_rdy, a_rv, b_rv, ren, rwe;
  logic [DW-1:0] rsp, rdi, rdo;
  logic [AW-1:0] rad;

  logic          t_a_rdy, t_b_rdy, t_a_rv, t_b_rv, t_ren, t_rwe;
  logic [DW-1:0] t_rsp, t_rdi;
  logic [DW-1:0] t_rdo;
  logic [AW-1:0] t_rad;
  assign t_rdo = '0;

  logic [DW-1:0] mem [16];

  int checks   = 0;
  int failures = 0;

  ram_sp_arbiter #(.DATA_WIDTH_P(DW), .ADDR_WIDTH_P(AW), .MAX_LOCK_P(16)) u_dut (
    .clk(clk), .rst(rst),
    .a_req_valid(a_v), .a_req_ready(a_rdy), .a_req_write(a_w), .a_req_lock(a_l),
    .a_req_addr(a_ad), .a_req_data(a_d),
    .b_req_valid(b_v), .b_req_ready(b_rdy), .b_req_write(b_w), .b_req_lock(b_l),
    .b_req_addr(b_ad), .b_req_data(b_d),
    .a_rsp_valid(a_rv), .b_rsp_valid(b_rv), .rsp_data(rsp),
    .ram_enable(ren), .ram_write_enable(rwe), .ram_address(rad),
    .ram_data_ingress(rdi), .ram_data_egress(rdo)
  );

  ram_sp_arbiter #(.DATA_WIDTH_P(DW), .ADDR_WIDTH_P(AW), .MAX_LOCK_P(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .a_req_valid(a_v), .a_req_ready(t_a_rdy), .a_req_write(a_w), .a_req_lock(a_l),
    .a_req_addr(a_ad), .a_req_data(a_d),
    .b_req_valid(b_v), .b_req_ready(t_b_rdy), .b_req_write(b_w), .b_req_lock(b_l),
    .b_req_addr(b_ad), .b_req_data(b_d),
    .a_rsp_valid(t_a_rv), .b_rsp_valid(t_b_rv), .rsp_data(t_rsp),
    .ram_enable(t_ren), .ram_write_enable(t_rwe), .ram_address(t_rad),
    .ram_data_ingress(t_rdi), .ram_data_egress(t_rdo)
  );

  // Single-port RAM, registered read, read-first; contents reload on reset.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'(8'hA0 + i);
      rdo <= '0;
    end else if (ren) begin
      if (rwe) mem[rad] <= rdi;
      rdo <= mem[rad];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_a(input logic v, w, l, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    a_v = v; a_w = w; a_l = l; a_ad = ad; a_d = d;
  endtask

  task automatic set_b(input logic v, w, l, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    b_v = v; b_w = w; b_l = l; b_ad = ad; b_d = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [6:0] pat;

  initial begin
    rst = 1'b1;
    set_a(1, 0, 0, 4'd1, 8'h00);
    set_b(1, 0, 0, 4'd2, 8'h00);
    #2;
    chk("rst_a_ready", a_rdy, 1'b0);
    chk("rst_b_ready", b_rdy, 1'b0);
    chk("rst_ram_en", ren, 1'b0);
    chk("rst_ram_addr", rad, 4'd0);
    step();
    step();
    rst = 1'b0;
    set_a(0, 0, 0, 4'd0, 8'h00);
    set_b(0, 0, 0, 4'd0, 8'h00);
    #1;
    chk("rst_a_rsp", a_rv, 1'b0);
    chk("rst_b_rsp", b_rv, 1'b0);
    chk("idle_ram_en", ren, 1'b0);

    // Conflict after reset: A reads addr 1, B reads addr 2, alternate A first
    set_a(1, 0, 0, 4'd1, 8'h00);
    set_b(1, 0, 0, 4'd2, 8'h00);
    for (int k = 0; k < 6; k++) begin
      #3;
      chk("conf_a_ready", a_rdy, (k % 2) == 0);
      chk("conf_b_ready", b_rdy, (k % 2) == 1);
      chk("conf_addr", rad, ((k % 2) == 0) ? 4'd1 : 4'd2);
      step();
      chk("conf_a_rsp", a_rv, (k % 2) == 0);
      chk("conf_b_rsp", b_rv, (k % 2) == 1);
      chk("conf_data", rsp, ((k % 2) == 0) ? 8'hA1 : 8'hA2);
    end
    set_b(0, 0, 0, 4'd0, 8'h00);

    // Single write then read by A
    set_a(1, 1, 0, 4'd3, 8'h5A);
    #3;
    chk("sw_a_ready", a_rdy, 1'b1);
    chk("sw_we", rwe, 1'b1);
    chk("sw_addr", rad, 4'd3);
    chk("sw_wdata", rdi, 8'h5A);
    step();
    chk("sw_no_rsp", a_rv, 1'b0);
    set_a(1, 0, 0, 4'd3, 8'h00);
    #3;
    chk("sr_a_ready", a_rdy, 1'b1);
    chk("sr_we", rwe, 1'b0);
    step();
    chk("sr_a_rsp", a_rv, 1'b1);
    chk("sr_data", rsp, 8'h5A);
    chk("sr_b_rsp", b_rv, 1'b0);
    set_a(0, 0, 0, 4'd0, 8'h00);

    // B-only read so B is last_grant before the burst
    set_b(1, 0, 0, 4'd5, 8'h00);
    step();
    chk("bonly_rsp", b_rv, 1'b1);
    chk("bonly_data", rsp, 8'hA5);

    // Locked burst: A writes addr 8..11 with lock 1,1,1,0; B waits on addr 6
    set_b(1, 0, 0, 4'd6, 8'h00);
    for (int i = 0; i < 4; i++) begin
      set_a(1, 1, i < 3, 4'(8 + i), 8'(8'hC0 + i));
      #3;
      chk("burst_a_ready", a_rdy, 1'b1);
      chk("burst_b_ready", b_rdy, 1'b0);
      step();
    end
    set_a(0, 0, 0, 4'd0, 8'h00);
    #3;
    chk("burst_b_granted", b_rdy, 1'b1);
    chk("burst_b_addr", rad, 4'd6);
    step();
    chk("burst_b_rsp", b_rv, 1'b1);
    chk("burst_b_data", rsp, 8'hA6);
    chk("burst_mem9", mem[9], 8'hC1);
    chk("burst_mem11", mem[11], 8'hC3);
    set_b(0, 0, 0, 4'd0, 8'h00);
    set_a(1, 0, 0, 4'd10, 8'h00);
    step();
    chk("burst_rd10", rsp, 8'hC2);

    // Write then read same address from the other port
    set_a(1, 1, 0, 4'd7, 8'h11);
    #3;
    chk("wr7_a_ready", a_rdy, 1'b1);
    step();
    set_a(0, 0, 0, 4'd0, 8'h00);
    set_b(1, 0, 0, 4'd7, 8'h00);
    #3;
    chk("rd7_b_ready", b_rdy, 1'b1);
    step();
    chk("rd7_b_rsp", b_rv, 1'b1);
    chk("rd7_data", rsp, 8'h11);
    chk("rd7_a_rsp", a_rv, 1'b0);

    // Reset while B holds the lock with a read in flight
    set_b(1, 0, 1, 4'd8, 8'h00);
    #3;
    chk("lkb_b_ready", b_rdy, 1'b1);
    step();
    chk("lkb_data", rsp, 8'hC0);
    set_a(1, 0, 0, 4'd1, 8'h00);
    set_b(1, 0, 1, 4'd9, 8'h00);
    #3;
    chk("lkb_a_blocked", a_rdy, 1'b0);
    chk("lkb_b_ready2", b_rdy, 1'b1);
    rst = 1'b1;
    #1;
    chk("mrst_a_ready", a_rdy, 1'b0);
    chk("mrst_b_ready", b_rdy, 1'b0);
    chk("mrst_ram_en", ren, 1'b0);
    step();
    chk("mrst_a_rsp", a_rv, 1'b0);
    chk("mrst_b_rsp", b_rv, 1'b0);
    rst = 1'b0;
    set_b(1, 0, 0, 4'd2, 8'h00);
    #3;
    chk("post_a_ready", a_rdy, 1'b1);
    chk("post_b_ready", b_rdy, 1'b0);
    step();
    chk("post_a_rsp", a_rv, 1'b1);
    chk("post_data", rsp, 8'hA1);

    // Lock timeout: MAX_LOCK_P=3 gives A,A,A,B,A,A,A; limit 16 keeps A
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_a(1, 0, 1, 4'd1, 8'h00);
    set_b(1, 0, 0, 4'd2, 8'h00);
    pat = 7'b1110111;
    for (int k = 0; k < 7; k++) begin
      #3;
      chk("tmo_a_ready", t_a_rdy, pat[k]);
      chk("tmo_b_ready", t_b_rdy, !pat[k]);
      chk("lk16_a_ready", a_rdy, 1'b1);
      chk("lk16_b_ready", b_rdy, 1'b0);
      step();
    end
    set_a(0, 0, 0, 4'd0, 8'h00);
    set_b(0, 0, 0, 4'd0, 8'h00);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
